// File: rtl/vrased_att_ctrl.sv
// vrased_att_ctrl: attestation session sequencer (clear RAM, drain DMA, enter SW-Att, watch for exit/violation/timeout)
// Ports: clk/reset_n (sync active-low); att_req host request; pc CPU program counter;
//        dma_en DMA activity; vrased_reset violation reset; clr_ram, dma_hold, irq_mask,
//        att_start, att_busy, att_done registered controls/status; att_err session outcome.
module vrased_att_ctrl #(
    parameter logic [15:0] SMEM_BASE  = 16'hA000,
    parameter logic [15:0] SMEM_EXIT  = 16'hDFFE,
    parameter int          CLR_CYCLES = 2,
    parameter int          DRAIN_MAX  = 64,
    parameter logic [15:0] RUN_MAX    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        att_req,
    input  logic [15:0] pc,
    input  logic        dma_en,
    input  logic        vrased_reset,
    output logic        clr_ram,
    output logic        dma_hold,
    output logic        irq_mask,
    output logic        att_start,
    output logic        att_busy,
    output logic        att_done,
    output logic [1:0]  att_err
);
    typedef enum logic [2:0] {IDLE, CLEAR, DRAIN, ENTER, RUN, DONE} state_t;
    state_t      state, nxt;
    logic [15:0] cnt, cnt_n;
    logic [1:0]  err_n;
    logic        viol;
    assign viol = vrased_reset && (state inside {CLEAR, DRAIN, ENTER, RUN});
    always_comb begin
        nxt   = state;
        cnt_n = cnt;
        err_n = att_err;
        case (state)
            IDLE: if (att_req) begin
                nxt   = CLEAR;
                cnt_n = 16'(CLR_CYCLES - 1);
                err_n = 2'b00;
            end
            CLEAR: begin
                nxt   = (cnt == 16'd0) ? DRAIN : CLEAR;
                cnt_n = (cnt == 16'd0) ? 16'd0 : cnt - 16'd1;
            end
            DRAIN:
                if (!dma_en) begin
                    nxt   = ENTER;
                    cnt_n = 16'd0;
                end else if (cnt == 16'(DRAIN_MAX - 1)) begin
                    nxt   = DONE;
                    err_n = 2'b11;
                end else
                    cnt_n = cnt + 16'd1;
            ENTER, RUN: begin
                cnt_n = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                // >= keeps the watchdog armed if an entry match consumed the exact limit cycle
                if (state == ENTER && pc == SMEM_BASE)
                    nxt = RUN;
                else if (state == RUN && pc == SMEM_EXIT) begin
                    nxt   = DONE;
                    err_n = 2'b00;
                end else if (cnt >= RUN_MAX - 16'd1) begin
                    nxt   = DONE;
                    err_n = 2'b10;
                end
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (viol) begin
            nxt   = DONE;
            err_n = 2'b01;
        end
    end
    // outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            att_err   <= 2'b00;
            clr_ram   <= 1'b0;
            dma_hold  <= 1'b0;
            irq_mask  <= 1'b0;
            att_start <= 1'b0;
            att_busy  <= 1'b0;
            att_done  <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_n;
            att_err   <= err_n;
            clr_ram   <= nxt == CLEAR;
            dma_hold  <= nxt inside {CLEAR, DRAIN, ENTER, RUN};
            irq_mask  <= nxt inside {ENTER, RUN};
            att_start <= state == DRAIN && nxt == ENTER;
            att_busy  <= nxt != IDLE;
            att_done  <= nxt == DONE;
        end
    end
endmodule

// File: tb/tb_vrased_att_ctrl.sv
// tb_vrased_att_ctrl: scoreboard bench for the attestation sequencer
module tb_vrased_att_ctrl;
    logic        clk = 0;
    logic        reset_n, att_req, dma_en, vrased_reset;
    logic [15:0] pc;
    logic        clr_ram, dma_hold, irq_mask, att_start, att_busy, att_done;
    logic [1:0]  att_err;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          c;

    typedef struct {bit done; int cyc; logic [1:0] err;} ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    vrased_att_ctrl #(.CLR_CYCLES(2), .DRAIN_MAX(4), .RUN_MAX(16'd16)) dut (
        .clk(clk), .reset_n(reset_n), .att_req(att_req), .pc(pc), .dma_en(dma_en),
        .vrased_reset(vrased_reset), .clr_ram(clr_ram), .dma_hold(dma_hold),
        .irq_mask(irq_mask), .att_start(att_start), .att_busy(att_busy),
        .att_done(att_done), .att_err(att_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (att_start || att_done) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: cycle %0d start=%0b done=%0b err=%0d, none expected",
                         cyc, att_start, att_done, att_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.done !== att_done || mon_e.cyc != cyc || (att_done && att_err !== mon_e.err)) begin
                    fails++;
                    $display("FAIL event: got done=%0b cycle %0d err=%0d, expected done=%0b cycle %0d err=%0d",
                             att_done, cyc, att_err, mon_e.done, mon_e.cyc, mon_e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic push(input bit done, input int at, input logic [1:0] err);
        exp_q.push_back('{done, at, err});
    endtask

    initial begin
        reset_n = 0; att_req = 0; pc = 16'h0100; dma_en = 0; vrased_reset = 0;
        repeat (3) @(negedge clk);
        chk("rst_clr_ram", {15'd0, clr_ram}, 0);
        chk("rst_dma_hold", {15'd0, dma_hold}, 0);
        chk("rst_irq_mask", {15'd0, irq_mask}, 0);
        chk("rst_att_start", {15'd0, att_start}, 0);
        chk("rst_att_busy", {15'd0, att_busy}, 0);
        chk("rst_att_done", {15'd0, att_done}, 0);
        chk("rst_att_err", {14'd0, att_err}, 0);
        reset_n = 1;
        @(negedge clk);

        // nominal session
        c = cyc; att_req = 1;
        push(0, c + 4, 0); push(1, c + 17, 2'b00);
        wait_to(c + 1); att_req = 0;
        chk("nom_clr_ram_1", {15'd0, clr_ram}, 1);
        chk("nom_busy", {15'd0, att_busy}, 1);
        wait_to(c + 2); chk("nom_clr_ram_2", {15'd0, clr_ram}, 1);
        wait_to(c + 3); chk("nom_clr_ram_off", {15'd0, clr_ram}, 0);
        chk("nom_hold_drain", {15'd0, dma_hold}, 1);
        wait_to(c + 6); pc = 16'hA000;
        wait_to(c + 16); pc = 16'hDFFE;
        chk("nom_irq_run", {15'd0, irq_mask}, 1);
        wait_to(c + 17); pc = 16'h0100;
        chk("nom_irq_done", {15'd0, irq_mask}, 0);
        chk("nom_hold_done", {15'd0, dma_hold}, 0);
        chk("nom_busy_done", {15'd0, att_busy}, 1);
        wait_to(c + 18);
        chk("nom_busy_idle", {15'd0, att_busy}, 0);
        chk("nom_err_held", {14'd0, att_err}, 0);

        // DMA busy for 3 drain samples, then quiet
        wait_to(c + 20); c = cyc; att_req = 1; dma_en = 1;
        push(0, c + 7, 0); push(1, c + 11, 2'b00);
        wait_to(c + 1); att_req = 0;
        wait_to(c + 5); chk("drain_hold", {15'd0, dma_hold}, 1);
        wait_to(c + 6); dma_en = 0;
        wait_to(c + 8); pc = 16'hA000;
        wait_to(c + 10); pc = 16'hDFFE;
        wait_to(c + 11); pc = 16'h0100;

        // DMA never quiet: drain timeout
        wait_to(c + 13); c = cyc; att_req = 1; dma_en = 1;
        push(1, c + 7, 2'b11);
        wait_to(c + 1); att_req = 0;
        wait_to(c + 7); chk("drain_to_err", {14'd0, att_err}, 16'h3);
        wait_to(c + 8); dma_en = 0;

        // violation during RUN
        wait_to(c + 10); c = cyc; att_req = 1;
        push(0, c + 4, 0); push(1, c + 8, 2'b01);
        wait_to(c + 1); att_req = 0;
        wait_to(c + 4); pc = 16'hA000;
        wait_to(c + 6); pc = 16'hA010;
        wait_to(c + 7); vrased_reset = 1;
        wait_to(c + 8); vrased_reset = 0; pc = 16'h0100;

        // violation coincident with exit
        wait_to(c + 10); c = cyc; att_req = 1;
        push(0, c + 4, 0); push(1, c + 8, 2'b01);
        wait_to(c + 1); att_req = 0;
        wait_to(c + 4); pc = 16'hA000;
        wait_to(c + 7); pc = 16'hDFFE; vrased_reset = 1;
        wait_to(c + 8); vrased_reset = 0; pc = 16'h0100;

        // watchdog: parked at entry
        wait_to(c + 10); c = cyc; att_req = 1;
        push(0, c + 4, 0); push(1, c + 20, 2'b10);
        wait_to(c + 1); att_req = 0;
        wait_to(c + 4); pc = 16'hA000;
        wait_to(c + 19); chk("wd_not_yet", {15'd0, att_done}, 0);
        wait_to(c + 20); chk("wd_err", {14'd0, att_err}, 16'h2);
        pc = 16'h0100;

        // reset mid-RUN: silent abort
        wait_to(c + 22); c = cyc; att_req = 1;
        push(0, c + 4, 0);
        wait_to(c + 1); att_req = 0;
        wait_to(c + 4); pc = 16'hA000;
        wait_to(c + 8); chk("mid_irq_before", {15'd0, irq_mask}, 1);
        reset_n = 0;
        wait_to(c + 9); reset_n = 1; pc = 16'h0100;
        chk("mid_busy", {15'd0, att_busy}, 0);
        chk("mid_irq", {15'd0, irq_mask}, 0);
        chk("mid_hold", {15'd0, dma_hold}, 0);
        chk("mid_done", {15'd0, att_done}, 0);
        chk("mid_err", {14'd0, att_err}, 0);

        // follow-up session with att_req held: one idle cycle between sessions
        wait_to(c + 12); c = cyc; att_req = 1;
        push(0, c + 4, 0); push(1, c + 6, 2'b00);
        push(0, c + 11, 0); push(1, c + 13, 2'b00);
        wait_to(c + 4); pc = 16'hA000;
        wait_to(c + 5); pc = 16'hDFFE;
        wait_to(c + 6); pc = 16'h0100;
        wait_to(c + 7); chk("chain_idle_gap", {15'd0, att_busy}, 0);
        wait_to(c + 8); att_req = 0;
        chk("chain_clr_ram", {15'd0, clr_ram}, 1);
        wait_to(c + 11); pc = 16'hA000;
        wait_to(c + 12); pc = 16'hDFFE;
        wait_to(c + 13); pc = 16'h0100;
        wait_to(c + 16);
        chk("events_pending", 16'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
